// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one byte-stream requester onto a registered UART TX byte port.
// Optional owner-idle forced release is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               timeout_q, timeout_d;

    logic [7:0]         req_data_arr [NUM_REQ];
    logic               out_free;
    logic               accept;
    logic               owner_last;
    logic               release_timeout;
    logic [IDX_W-1:0]   owner_next_ptr;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign req_data_arr[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    // The output register can take a byte when empty or when it drains this cycle.
    assign out_free       = !tx_valid_q || tx_ready_i;
    assign req_ready_o    = (state_q == ST_LOCKED && out_free) ? grant_q : '0;
    assign accept         = |(req_valid_i & req_ready_o);
    assign owner_last     = req_last_i[owner_q];
    assign owner_next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d      = '0;
        release_timeout = 1'b0;
        if (state_q == ST_LOCKED && !accept) begin
            if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                release_timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign release_timeout    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        timeout_d  = 1'b0;

        if (tx_valid_q && tx_ready_i) begin
            tx_valid_d = 1'b0;
        end
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = req_data_arr[owner_q];
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_LOCKED;
                    grant_d = NUM_REQ'(1) << sel_idx;
                    owner_d = sel_idx;
                end
            end
            default: begin
                if (accept && owner_last) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_next_ptr;
                end else if (release_timeout) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_next_ptr;
                    timeout_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant_o    = grant_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q == ST_LOCKED) || tx_valid_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter: table of per-cycle vectors plus hand sequences
// for lock hold / forced release and mid-message reset.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready = 1'b1;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        txr;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic r, input logic [3:0] g, input logic [3:0] rdy,
                                input logic txv, input logic [7:0] txd, input logic b);
        vec_t x;
        x.valid = v; x.data = d; x.last = l; x.txr = r;
        x.e_grant = g; x.e_ready = rdy; x.e_txv = txv; x.e_txd = txd; x.e_busy = b;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] rdy,
                           input logic txv, input logic [7:0] txd, input logic b, input logic to);
        chk({tag, ".grant"},   32'(grant),     32'(g));
        chk({tag, ".ready"},   32'(req_ready), 32'(rdy));
        chk({tag, ".txv"},     32'(tx_valid),  32'(txv));
        chk({tag, ".txd"},     32'(tx_data),   32'(txd));
        chk({tag, ".busy"},    32'(busy),      32'(b));
        chk({tag, ".timeout"}, 32'(timeout),   32'(to));
        $display("%s: grant=%b ready=%b txv=%b txd=%h busy=%b to=%b",
                 tag, grant, req_ready, tx_valid, tx_data, busy, timeout);
    endtask

    // Drive inputs just after the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic rst, input logic [3:0] v, input logic [31:0] d,
                        input logic [3:0] l, input logic r);
        @(negedge clk);
        rst_n = rst; req_valid = v; req_data = d; req_last = l; tx_ready = r;
        #1;
    endtask

    initial begin
        logic [3:0] owner;
        logic [3:0] e_g, e_r;
        logic       e_v, e_b, e_t;
        logic [7:0] e_d;

        // Requester 2 message, then all four hold 1-byte messages.
        vecs.push_back(mk(4'b0100, 32'h00410000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk(4'b0100, 32'h00410000, 4'b0000, 1, 4'b0100, 4'b0100, 0, 8'h00, 1));
        vecs.push_back(mk(4'b0100, 32'h00420000, 4'b0000, 1, 4'b0100, 4'b0100, 1, 8'h41, 1));
        vecs.push_back(mk(4'b0100, 32'h00430000, 4'b0100, 1, 4'b0100, 4'b0100, 1, 8'h42, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'h43, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h43, 0));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0000, 4'b0000, 0, 8'h43, 0));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b1000, 4'b1000, 0, 8'h43, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0000, 4'b0000, 1, 8'h33, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0001, 4'b0001, 0, 8'h33, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0000, 4'b0000, 1, 8'h30, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0010, 4'b0010, 0, 8'h30, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0000, 4'b0000, 1, 8'h31, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0100, 4'b0100, 0, 8'h31, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0000, 4'b0000, 1, 8'h32, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b1000, 4'b1000, 0, 8'h32, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0000, 4'b0000, 1, 8'h33, 1));
        vecs.push_back(mk(4'b1111, 32'h33323130, 4'b1111, 1, 4'b0001, 4'b0001, 0, 8'h33, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'h30, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h30, 0));
        // Backpressure on requester 1 while requester 0 competes.
        vecs.push_back(mk(4'b0010, 32'h00005500, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h30, 0));
        vecs.push_back(mk(4'b0010, 32'h00005500, 4'b0000, 1, 4'b0010, 4'b0010, 0, 8'h30, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0011, 32'h000066EE, 4'b0011, 0, 4'b0010, 4'b0000, 1, 8'h55, 1));
        vecs.push_back(mk(4'b0010, 32'h000066EE, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'h55, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'h66, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'h66, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h66, 0));

        // Reset with all requesters asserting.
        step(0, 4'b1111, 32'h33323130, 4'b1111, 1);
        step(0, 4'b1111, 32'h33323130, 4'b1111, 1);
        chk_all("reset", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            step(1, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].txr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_ready,
                    vecs[i].e_txv, vecs[i].e_txd, vecs[i].e_busy, 1'b0);
        end

        // Requester 0 sends 0x10 without last, then idles while requester 1 waits.
        step(1, 4'b0001, 32'h00000010, 4'b0000, 1);
        chk_all("lk_bubble", 4'b0000, 4'b0000, 0, 8'h66, 0, 0);
        step(1, 4'b0001, 32'h00000010, 4'b0000, 1);
        chk_all("lk_accept", 4'b0001, 4'b0001, 0, 8'h66, 1, 0);
        for (int c = 0; c < 20; c++) begin
            step(1, 4'b0010, 32'h0000EE00, 4'b0000, 1);
`ifdef UART_ARB_TIMEOUT_EN
            if (c < 8) begin
                e_g = 4'b0001; e_r = 4'b0001; e_v = (c == 0); e_d = 8'h10; e_b = 1; e_t = 0;
            end else if (c == 8) begin
                e_g = 4'b0000; e_r = 4'b0000; e_v = 0; e_d = 8'h10; e_b = 0; e_t = 1;
            end else if (c == 9) begin
                e_g = 4'b0010; e_r = 4'b0010; e_v = 0; e_d = 8'h10; e_b = 1; e_t = 0;
            end else begin
                e_g = 4'b0010; e_r = 4'b0010; e_v = 1; e_d = 8'hEE; e_b = 1; e_t = 0;
            end
`else
            e_g = 4'b0001; e_r = 4'b0001; e_v = (c == 0); e_d = 8'h10; e_b = 1; e_t = 0;
`endif
            chk_all($sformatf("lk_hold%0d", c), e_g, e_r, e_v, e_d, e_b, e_t);
        end

        // Reset while the owner's byte is held in the output register.
`ifdef UART_ARB_TIMEOUT_EN
        owner = 4'b0010;
`else
        owner = 4'b0001;
`endif
        step(1, owner, 32'h77777777, 4'b0000, 1);
        step(1, owner, 32'h77777777, 4'b0000, 0);
        chk_all("mid_held", owner, 4'b0000, 1, 8'h77, 1, 0);
        step(0, 4'b1111, 32'h77777777, 4'b0000, 1);
        step(1, 4'b1111, 32'h03020100, 4'b1111, 1);
        chk_all("mid_reset", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        step(1, 4'b1111, 32'h03020100, 4'b1111, 1);
        chk_all("post_reset", 4'b0001, 4'b0001, 0, 8'h00, 1, 0);
        step(1, 4'b0000, 32'h00000000, 4'b0000, 1);
        chk_all("post_byte", 4'b0000, 4'b0000, 1, 8'h00, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
